vend_credit_fsm: RTL and testbench

- Downstream of the per-button one-pulse stages in the vending machine. Consumes their single-cycle pulses: three coin buttons, one select button and one cancel button.
- Accumulates credit in cents, dispenses one item at PRICE, and returns change as a train of nickel pulses.
- Drives the dispense actuator and the change-return mechanism directly.

---
 rtl/vend_credit_fsm.sv | 179 +++++++++++++++++
 tb/tb_vend_credit_fsm.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vend_credit_fsm.sv
// Vending machine credit controller: accumulates coin credit, vends at PRICE, returns change as nickel pulses.
// Optional REVENUE_CNT_EN adds a saturating 16-bit Revenue counter output.
module vend_credit_fsm #(
    parameter int PRICE           = 65,
    parameter int MAX_CREDIT      = 95,
    parameter int DISPENSE_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        rst,
    input  logic        Nickel,
    input  logic        Dime,
    input  logic        Quarter,
    input  logic        Select,
    input  logic        Cancel,
    output logic [6:0]  Credit,
    output logic        Dispense,
    output logic        ChangeNickel,
    output logic        CoinReject,
    output logic        NoFunds,
`ifdef REVENUE_CNT_EN
    output logic [15:0] Revenue,
`endif
    output logic        Busy
);

    localparam int CW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
    localparam logic [6:0]    PRICE_C   = 7'(PRICE);
    localparam logic [7:0]    MAX_C     = 8'(MAX_CREDIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DISPENSE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCUM    = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3
    } state_t;

    state_t          state_r;
    logic [6:0]      credit_r;
    logic [CW-1:0]   cnt_r;
    logic            gap_r;
    logic            dispense_r;
    logic            change_nickel_r;
    logic            coin_reject_r;
    logic            no_funds_r;
    logic            busy_r;
    logic [5:0]      coin_val_s;
    logic            coin_any_s;
    logic [7:0]      sum_s;

    // Coin value of this cycle and the 8-bit candidate credit, wide enough that it cannot wrap
    always_comb begin
        coin_val_s = (Nickel  ? 6'd5  : 6'd0)
                   + (Dime    ? 6'd10 : 6'd0)
                   + (Quarter ? 6'd25 : 6'd0);
        coin_any_s = Nickel | Dime | Quarter;
        sum_s      = {1'b0, credit_r} + {2'b00, coin_val_s};
    end

    // Main controller: state, credit and all registered outputs
    always_ff @(posedge Clk) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            credit_r        <= 7'd0;
            cnt_r           <= '0;
            gap_r           <= 1'b0;
            dispense_r      <= 1'b0;
            change_nickel_r <= 1'b0;
            coin_reject_r   <= 1'b0;
            no_funds_r      <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            change_nickel_r <= 1'b0;
            coin_reject_r   <= 1'b0;
            no_funds_r      <= 1'b0;
            case (state_r)
                ST_IDLE, ST_ACCUM: begin
                    if (Cancel && (credit_r != 7'd0)) begin
                        state_r       <= ST_CHANGE;
                        busy_r        <= 1'b1;
                        gap_r         <= 1'b0;
                        coin_reject_r <= coin_any_s;
                    end else if (Select && (credit_r >= PRICE_C)) begin
                        state_r       <= ST_DISPENSE;
                        credit_r      <= credit_r - PRICE_C;
                        dispense_r    <= 1'b1;
                        busy_r        <= 1'b1;
                        cnt_r         <= '0;
                        coin_reject_r <= coin_any_s;
                    end else begin
                        // Select reaching here is always short of funds; coins still count
                        no_funds_r <= Select;
                        if (coin_any_s) begin
                            if (sum_s <= MAX_C) begin
                                credit_r <= sum_s[6:0];
                                state_r  <= ST_ACCUM;
                            end else begin
                                coin_reject_r <= 1'b1;
                            end
                        end else begin
                            state_r <= (credit_r == 7'd0) ? ST_IDLE : ST_ACCUM;
                        end
                    end
                end
                ST_DISPENSE: begin
                    coin_reject_r <= coin_any_s;
                    if (cnt_r == CNT_LAST) begin
                        dispense_r <= 1'b0;
                        gap_r      <= 1'b0;
                        if (credit_r != 7'd0) begin
                            state_r <= ST_CHANGE;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_CHANGE: begin
                    coin_reject_r <= coin_any_s;
                    if (gap_r) begin
                        gap_r <= 1'b0;
                    end else if (credit_r != 7'd0) begin
                        change_nickel_r <= 1'b1;
                        credit_r        <= credit_r - 7'd5;
                        gap_r           <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    credit_r   <= 7'd0;
                    cnt_r      <= '0;
                    gap_r      <= 1'b0;
                    dispense_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

`ifdef REVENUE_CNT_EN
    logic        vend_s;
    logic [16:0] rev_sum_s;
    logic [15:0] revenue_r;

    // Detects the edge that enters DISPENSE and forms the widened revenue sum
    always_comb begin
        vend_s    = ((state_r == ST_IDLE) || (state_r == ST_ACCUM))
                  && !(Cancel && (credit_r != 7'd0))
                  && Select && (credit_r >= PRICE_C);
        rev_sum_s = {1'b0, revenue_r} + 17'(PRICE);
    end

    // Saturating revenue counter
    always_ff @(posedge Clk) begin
        if (!rst) begin
            revenue_r <= 16'd0;
        end else if (vend_s) begin
            revenue_r <= rev_sum_s[16] ? 16'hFFFF : rev_sum_s[15:0];
        end else begin
            revenue_r <= revenue_r;
        end
    end

    assign Revenue = revenue_r;
`endif

    assign Credit       = credit_r;
    assign Dispense     = dispense_r;
    assign ChangeNickel = change_nickel_r;
    assign CoinReject   = coin_reject_r;
    assign NoFunds      = no_funds_r;
    assign Busy         = busy_r;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Directed bench for vend_credit_fsm: cycle-by-cycle vector table plus hand-written change/dispense sequences.
module tb_vend_credit_fsm;

    logic       Clk = 1'b0;
    logic       rst = 1'b0;
    logic       Nickel = 1'b0, Dime = 1'b0, Quarter = 1'b0, Select = 1'b0, Cancel = 1'b0;
    logic [6:0] Credit;
    logic       Dispense, ChangeNickel, CoinReject, NoFunds, Busy;
`ifdef REVENUE_CNT_EN
    logic [15:0] Revenue;
`endif

    int n_pass  = 0;
    int n_total = 0;

    vend_credit_fsm dut (
        .Clk(Clk), .rst(rst), .Nickel(Nickel), .Dime(Dime), .Quarter(Quarter),
        .Select(Select), .Cancel(Cancel), .Credit(Credit), .Dispense(Dispense),
        .ChangeNickel(ChangeNickel), .CoinReject(CoinReject), .NoFunds(NoFunds),
`ifdef REVENUE_CNT_EN
        .Revenue(Revenue),
`endif
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       r, n, d, q, s, c;
        logic [6:0] credit;
        logic       dp, cn, rj, nf, bz;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic r, n, d, q, s, c,
                               input logic [6:0] credit,
                               input logic dp, cn, rj, nf, bz);
        vec_t x;
        x.r = r; x.n = n; x.d = d; x.q = q; x.s = s; x.c = c;
        x.credit = credit; x.dp = dp; x.cn = cn; x.rj = rj; x.nf = nf; x.bz = bz;
        return x;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic drive(input logic r, n, d, q, s, c);
        @(negedge Clk);
        rst = r; Nickel = n; Dime = d; Quarter = q; Select = s; Cancel = c;
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [11:0] outs();
        return {Credit, Dispense, ChangeNickel, CoinReject, NoFunds, Busy};
    endfunction

    initial begin
        int  dcnt, ncnt;
        logic prev_cn, adj, done;

        // rst, n, d, q, s, c | credit, dispense, change, reject, nofunds, busy
        vq.push_back(v(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 7'd0,  1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 7'd0,  1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 7'd25, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 7'd50, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 7'd60, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 7'd65, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 7'd0,  1'b1,1'b0,1'b0,1'b0,1'b1));
        for (int i = 0; i < 3; i++)
            vq.push_back(v(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 7'd0, 1'b1,1'b0,1'b0,1'b0,1'b1));
        vq.push_back(v(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 7'd0,  1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 7'd0,  1'b0,1'b0,1'b0,1'b1,1'b0));
        // Build to 90 then overflow
        vq.push_back(v(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 7'd25, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 7'd50, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 7'd75, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 7'd85, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 7'd90, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 7'd90, 1'b0,1'b0,1'b1,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 7'd95, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 7'd95, 1'b0,1'b0,1'b1,1'b0,1'b0));
        vq.push_back(v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 7'd0,  1'b0,1'b0,1'b0,1'b0,1'b0));
        // Credit 80 then Nickel+Dime lands exactly on MAX_CREDIT
        vq.push_back(v(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 7'd25, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 7'd50, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 7'd75, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 7'd80, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 7'd95, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b1,1'b1,1'b1,1'b0,1'b0, 7'd95, 1'b0,1'b0,1'b1,1'b0,1'b0));
        vq.push_back(v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 7'd0,  1'b0,1'b0,1'b0,1'b0,1'b0));
        // Insufficient funds at 30
        vq.push_back(v(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 7'd25, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 7'd30, 1'b0,1'b0,1'b0,1'b0,1'b0));
        vq.push_back(v(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 7'd30, 1'b0,1'b0,1'b0,1'b1,1'b0));
        vq.push_back(v(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 7'd30, 1'b0,1'b0,1'b0,1'b0,1'b0));

        foreach (vq[i]) begin
            drive(vq[i].r, vq[i].n, vq[i].d, vq[i].q, vq[i].s, vq[i].c);
            chk($sformatf("vec%0d", i), 16'(outs()),
                16'({vq[i].credit, vq[i].dp, vq[i].cn, vq[i].rj, vq[i].nf, vq[i].bz}));
        end

        // Cancel+Select at credit 30: cancel wins, six nickels, never dispenses
        drive(1'b1,1'b0,1'b0,1'b0,1'b1,1'b1);
        chk("cancel_enter", 16'(outs()), 16'({7'd30, 1'b0,1'b0,1'b0,1'b0,1'b1}));
        dcnt = 0; ncnt = 0; prev_cn = 1'b0; adj = 1'b0; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            drive(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0);
            if (Dispense) dcnt++;
            if (ChangeNickel) ncnt++;
            if (ChangeNickel && prev_cn) adj = 1'b1;
            prev_cn = ChangeNickel;
            if (!Busy) done = 1'b1;
        end
        chk("cancel_done", 16'(done), 16'(1));
        chk("cancel_nickels", 16'(ncnt), 16'(6));
        chk("cancel_no_dispense", 16'(dcnt), 16'(0));
        chk("cancel_gap", 16'(adj), 16'(0));
        chk("cancel_credit", 16'(Credit), 16'(0));

        // Vend with change: 75 credit, 4 dispense cycles, two separated nickels
        for (int k = 0; k < 3; k++) drive(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0);
        chk("chg_credit75", 16'(Credit), 16'(75));
        drive(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0);
        chk("chg_select", 16'(outs()), 16'({7'd10, 1'b1,1'b0,1'b0,1'b0,1'b1}));
        dcnt = 1; ncnt = 0; prev_cn = 1'b0; adj = 1'b0; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            drive(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0);
            if (Dispense) dcnt++;
            if (ChangeNickel) ncnt++;
            if (ChangeNickel && prev_cn) adj = 1'b1;
            prev_cn = ChangeNickel;
            if (!Busy) done = 1'b1;
        end
        chk("chg_done", 16'(done), 16'(1));
        chk("chg_dispense_cycles", 16'(dcnt), 16'(4));
        chk("chg_nickels", 16'(ncnt), 16'(2));
        chk("chg_gap", 16'(adj), 16'(0));
        chk("chg_final", 16'(outs()), 16'({7'd0, 1'b0,1'b0,1'b0,1'b0,1'b0}));
`ifdef REVENUE_CNT_EN
        chk("revenue_one_vend", Revenue, 16'd65);
`endif

        // Coin while dispensing, then reset in the second dispense cycle
        for (int k = 0; k < 3; k++) drive(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0);
        drive(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0);
        chk("busy_vend", 16'(outs()), 16'({7'd10, 1'b1,1'b0,1'b0,1'b0,1'b1}));
        drive(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0);
        chk("busy_coin_reject", 16'(outs()), 16'({7'd10, 1'b1,1'b0,1'b1,1'b0,1'b1}));
`ifdef REVENUE_CNT_EN
        chk("revenue_two_vends", Revenue, 16'd130);
`endif
        drive(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
        chk("mid_reset", 16'(outs()), 16'({7'd0, 1'b0,1'b0,1'b0,1'b0,1'b0}));
`ifdef REVENUE_CNT_EN
        chk("revenue_reset", Revenue, 16'd0);
`endif
        drive(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0);
        chk("after_reset_idle", 16'(outs()), 16'({7'd0, 1'b0,1'b0,1'b0,1'b0,1'b0}));
        drive(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0);
        chk("after_reset_quarter", 16'(outs()), 16'({7'd25, 1'b0,1'b0,1'b0,1'b0,1'b0}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
